// File: rtl/alu_cond_writeback_pkg.sv
// Shared definitions for the ALU conditional write-back stage and its flag register.
package alu_cond_writeback_pkg;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_CARRY  = 2'b10;
  localparam logic [1:0] COND_ZERO   = 2'b01;
  localparam logic [1:0] COND_RSVD   = 2'b11;

  localparam int PC_REG_DEFAULT = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/alu_cond_writeback_flag_reg.sv
// Architectural C/Z flag register with independent per-flag load enables.
module wb_flag_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic c_en,
  input  logic c_in,
  input  logic z_en,
  input  logic z_in,
  output logic c_flag,
  output logic z_flag
);

  logic c_q, c_d;
  logic z_q, z_d;

  always_comb begin
    c_d = c_en ? c_in : c_q;
    z_d = z_en ? z_in : z_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      c_q <= c_d;
      z_q <= z_d;
    end
  end

  assign c_flag = c_q;
  assign z_flag = z_q;

endmodule

// File: rtl/alu_cond_writeback.sv
// Captures an ALU result, evaluates its execute condition against C/Z and
// performs the handshaked register-file write plus flag commit.
module alu_cond_writeback
  import alu_cond_writeback_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int PC_REG = PC_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic [1:0]        cond,
  input  logic [REG_AW-1:0] dest,
  input  logic              rf_wr_req,
  input  logic              upd_c,
  input  logic              upd_z,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  output logic              pc_load,
  output logic              c_flag,
  output logic              z_flag,
  output logic              done,
  output logic              squashed,
  output logic              illegal
);

  wb_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic [1:0]        cond_q, cond_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              wr_req_q, wr_req_d;
  logic              upd_c_q, upd_c_d;
  logic              upd_z_q, upd_z_d;
  logic              squashed_q, squashed_d;
  logic              illegal_q, illegal_d;
  logic              exec;
  logic              c_en, z_en;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    cond_d     = cond_q;
    dest_d     = dest_q;
    wr_req_d   = wr_req_q;
    upd_c_d    = upd_c_q;
    upd_z_d    = upd_z_q;
    squashed_d = squashed_q;
    illegal_d  = illegal_q;
    exec       = 1'b0;
    c_en       = 1'b0;
    z_en       = 1'b0;

    unique case (cond_q)
      COND_ALWAYS: exec = 1'b1;
      COND_CARRY:  exec = c_flag;
      COND_ZERO:   exec = z_flag;
      default:     exec = 1'b0;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d     = alu_out;
          carry_d    = alu_carry;
          zero_d     = alu_zero;
          cond_d     = cond;
          dest_d     = dest;
          wr_req_d   = rf_wr_req;
          upd_c_d    = upd_c;
          upd_z_d    = upd_z;
          squashed_d = 1'b0;
          illegal_d  = 1'b0;
          state_d    = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (exec && wr_req_q) begin
          state_d = ST_WRITE;
        end else if (exec) begin
          // No register write: flags commit straight from evaluation.
          c_en    = upd_c_q;
          z_en    = upd_z_q;
          state_d = ST_DONE;
        end else begin
          squashed_d = 1'b1;
          illegal_d  = (cond_q == COND_RSVD);
          state_d    = ST_DONE;
        end
      end
      ST_WRITE: begin
        // A flush in the handshake cycle abandons the write and the flags.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (rf_ready) begin
          c_en    = upd_c_q;
          z_en    = upd_z_q;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      cond_q     <= COND_ALWAYS;
      dest_q     <= '0;
      wr_req_q   <= 1'b0;
      upd_c_q    <= 1'b0;
      upd_z_q    <= 1'b0;
      squashed_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      cond_q     <= cond_d;
      dest_q     <= dest_d;
      wr_req_q   <= wr_req_d;
      upd_c_q    <= upd_c_d;
      upd_z_q    <= upd_z_d;
      squashed_q <= squashed_d;
      illegal_q  <= illegal_d;
    end
  end

  wb_flag_reg u_flags (
    .clk    (clk),
    .rst_n  (rst_n),
    .c_en   (c_en),
    .c_in   (carry_q),
    .z_en   (z_en),
    .z_in   (zero_q),
    .c_flag (c_flag),
    .z_flag (z_flag)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign rf_we    = (state_q == ST_WRITE);
  assign rf_waddr = dest_q;
  assign rf_wdata = data_q;
  assign pc_load  = rf_we && (dest_q == REG_AW'(PC_REG));
  assign done     = (state_q == ST_DONE);
  assign squashed = done && squashed_q;
  assign illegal  = done && illegal_q;

endmodule

// File: tb/tb_alu_cond_writeback.sv
// Randomised self-checking bench for alu_cond_writeback against a flag/condition model.
module tb_alu_cond_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic        alu_carry;
  logic        alu_zero;
  logic [1:0]  cond;
  logic [2:0]  dest;
  logic        rf_wr_req;
  logic        upd_c;
  logic        upd_z;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_ready;
  logic        pc_load;
  logic        c_flag;
  logic        z_flag;
  logic        done;
  logic        squashed;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;
  logic m_c = 1'b0;
  logic m_z = 1'b0;

  always #5 clk = ~clk;

  alu_cond_writeback dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero), .cond(cond),
    .dest(dest), .rf_wr_req(rf_wr_req), .upd_c(upd_c), .upd_z(upd_z),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .pc_load(pc_load), .c_flag(c_flag), .z_flag(z_flag), .done(done),
    .squashed(squashed), .illegal(illegal)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // fl_mode: 0 none, 1 flush while evaluating, 2 flush together with rf_ready in the write
  task automatic run_op(input logic [1:0] cnd, input logic [2:0] dst, input logic [15:0] dat,
                        input logic cy, input logic zr, input logic wr, input logic uc,
                        input logic uz, input int stalls, input int fl_mode);
    logic ex, exp_wr, exp_c, exp_z;
    int   fl, wcnt, lat;
    bit   ended, fl_applied;
    case (cnd)
      2'b00:   ex = 1'b1;
      2'b10:   ex = m_c;
      2'b01:   ex = m_z;
      default: ex = 1'b0;
    endcase
    exp_wr = ex && wr;
    fl = fl_mode;
    if (fl == 2 && !exp_wr) fl = 0;
    exp_c = (ex && uc && fl == 0) ? cy : m_c;
    exp_z = (ex && uz && fl == 0) ? zr : m_z;

    check_val("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; cond = cnd; dest = dst; alu_out = dat; alu_carry = cy;
    alu_zero = zr; rf_wr_req = wr; upd_c = uc; upd_z = uz;
    @(negedge clk);
    in_valid = 1'b0;
    alu_out = 16'($urandom); alu_carry = 1'($urandom); alu_zero = 1'($urandom);
    dest = 3'($urandom); cond = 2'($urandom);

    wcnt = 0; ended = 0; fl_applied = 0; lat = exp_wr ? stalls + 2 : 1;
    for (int i = 0; i < 64 && !ended; i++) begin
      if (fl_applied) begin
        check_val("flush_ready", in_ready, 1);
        check_val("flush_nodone", done, 0);
        check_val("flush_we", rf_we, 0);
        check_val("flush_c", c_flag, m_c);
        check_val("flush_z", z_flag, m_z);
        ended = 1;
      end else if (done) begin
        check_val("latency", i, lat);
        check_val("squashed", squashed, !ex);
        check_val("illegal", illegal, cnd == 2'b11);
        check_val("write_cycles", wcnt, exp_wr ? stalls + 1 : 0);
        check_val("c_after", c_flag, exp_c);
        check_val("z_after", z_flag, exp_z);
        ended = 1;
      end else begin
        if (i == 0) check_val("in_ready_busy", in_ready, 0);
        flush = 1'b0;
        rf_ready = 1'($urandom);
        if (i == 0 && fl == 1) begin
          flush = 1'b1; fl_applied = 1;
        end
        if (rf_we) begin
          wcnt++;
          check_val("waddr", rf_waddr, dst);
          check_val("wdata", rf_wdata, dat);
          check_val("pc_load", pc_load, dst == 3'd7);
          check_val("c_hold", c_flag, m_c);
          check_val("z_hold", z_flag, m_z);
          rf_ready = (wcnt > stalls);
          if (fl == 2 && wcnt > stalls) begin
            flush = 1'b1; fl_applied = 1;
          end
        end
      end
      if (!ended) @(negedge clk);
    end
    flush = 1'b0;
    if (!ended) check_val("timeout", 0, 1);
    if (!fl_applied) begin
      @(negedge clk);
      check_val("done_pulse", done, 0);
      check_val("ready_after", in_ready, 1);
    end
    $display("op cond=%b dest=%0d data=%h c=%b z=%b wr=%b uc=%b uz=%b stalls=%0d flush=%0d -> C=%b Z=%b",
             cnd, dst, dat, cy, zr, wr, uc, uz, stalls, fl, c_flag, z_flag);
    m_c = exp_c;
    m_z = exp_z;
  endtask

  task automatic set_flags(input logic c, input logic z);
    run_op(2'b00, 3'd0, 16'h0, c, z, 1'b0, 1'b1, 1'b1, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_out = '0; alu_carry = 1'b0;
    alu_zero = 1'b0; cond = 2'b00; dest = '0; rf_wr_req = 1'b0; upd_c = 1'b0;
    upd_z = 1'b0; rf_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_we", rf_we, 0);
    check_val("rst_pc_load", pc_load, 0);
    check_val("rst_done", done, 0);
    check_val("rst_squashed", squashed, 0);
    check_val("rst_illegal", illegal, 0);
    check_val("rst_c", c_flag, 0);
    check_val("rst_z", z_flag, 0);
    check_val("rst_waddr", rf_waddr, 0);
    check_val("rst_wdata", rf_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 3'd3, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    set_flags(1'b0, 1'b0);
    run_op(2'b10, 3'd2, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    set_flags(1'b1, 1'b0);
    run_op(2'b10, 3'd2, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    set_flags(1'b1, 1'b1);
    run_op(2'b01, 3'd4, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
    run_op(2'b00, 3'd7, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 0);
    run_op(2'b11, 3'd1, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    run_op(2'b00, 3'd6, 16'hA5A5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 2);
    run_op(2'b00, 3'd6, 16'hA5A5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1);

    // Asynchronous reset in the middle of a stalled write
    set_flags(1'b1, 1'b1);
    in_valid = 1'b1; cond = 2'b00; dest = 3'd5; alu_out = 16'h7777; rf_wr_req = 1'b1;
    upd_c = 1'b1; upd_z = 1'b1; alu_carry = 1'b0; alu_zero = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; rf_ready = 1'b0;
    @(negedge clk);
    check_val("pre_rst_we", rf_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_we", rf_we, 0);
    check_val("async_rst_c", c_flag, 0);
    check_val("async_rst_z", z_flag, 0);
    check_val("async_rst_waddr", rf_waddr, 0);
    $display("op async reset during write -> we=%b C=%b Z=%b", rf_we, c_flag, z_flag);
    @(negedge clk);
    rst_n = 1'b1;
    m_c = 1'b0; m_z = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 80; k++) begin
      run_op(2'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
